// File: rtl/kbd_ps2_rx.sv
// PS/2 set-2 keyboard receiver: synchronizes the device lines, deframes bytes and
// translates make/break codes into the Hack KEYBOARD word.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a start bit (falling edge with data low)
// ST_DATA   | shifting in the 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, then acting on the byte
module kbd_ps2_rx #(
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    key_q, key_d;
    logic          frame_valid_q, frame_valid_d;
    logic          frame_err_q, frame_err_d;

    logic          fall;
    logic          din;
    logic [7:0]    xlat;
    logic          xlat_hit;

    assign fall = clk_prev_q & ~clk_s2_q;
    assign din  = dat_s2_q;

    // Every mapped Hack code is nonzero, so zero doubles as "unmapped".
    always_comb begin
        xlat = 8'd0;
        if (ext_q) begin
            case (shift_q)
                8'h6B:   xlat = 8'd130;
                8'h75:   xlat = 8'd131;
                8'h74:   xlat = 8'd132;
                8'h72:   xlat = 8'd133;
                default: xlat = 8'd0;
            endcase
        end else begin
            case (shift_q)
                8'h1C: xlat = 8'd65;
                8'h32: xlat = 8'd66;
                8'h21: xlat = 8'd67;
                8'h23: xlat = 8'd68;
                8'h24: xlat = 8'd69;
                8'h2B: xlat = 8'd70;
                8'h34: xlat = 8'd71;
                8'h33: xlat = 8'd72;
                8'h43: xlat = 8'd73;
                8'h3B: xlat = 8'd74;
                8'h42: xlat = 8'd75;
                8'h4B: xlat = 8'd76;
                8'h3A: xlat = 8'd77;
                8'h31: xlat = 8'd78;
                8'h44: xlat = 8'd79;
                8'h4D: xlat = 8'd80;
                8'h15: xlat = 8'd81;
                8'h2D: xlat = 8'd82;
                8'h1B: xlat = 8'd83;
                8'h2C: xlat = 8'd84;
                8'h3C: xlat = 8'd85;
                8'h2A: xlat = 8'd86;
                8'h1D: xlat = 8'd87;
                8'h22: xlat = 8'd88;
                8'h35: xlat = 8'd89;
                8'h1A: xlat = 8'd90;
                8'h45: xlat = 8'd48;
                8'h16: xlat = 8'd49;
                8'h1E: xlat = 8'd50;
                8'h26: xlat = 8'd51;
                8'h25: xlat = 8'd52;
                8'h2E: xlat = 8'd53;
                8'h36: xlat = 8'd54;
                8'h3D: xlat = 8'd55;
                8'h3E: xlat = 8'd56;
                8'h46: xlat = 8'd57;
                8'h29: xlat = 8'd32;
                8'h5A: xlat = 8'd128;
                8'h66: xlat = 8'd129;
                8'h76: xlat = 8'd140;
                default: xlat = 8'd0;
            endcase
        end
        xlat_hit = (xlat != 8'd0);
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        tmr_d         = tmr_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_d         = key_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        if (state_q == ST_IDLE) begin
            tmr_d     = '0;
            bit_cnt_d = 3'd0;
            if (fall && !din) begin
                state_d = ST_DATA;
                tmr_d   = TMR_LOAD;
            end
        end else if (fall) begin
            tmr_d = TMR_LOAD;
            case (state_q)
                ST_DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = din;
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (din && (^{shift_q, par_q})) begin
                        frame_valid_d = 1'b1;
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            if (xlat_hit) begin
                                if (!brk_q)             key_d = xlat;
                                else if (key_q == xlat) key_d = 8'd0;
                            end
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
            endcase
        end else if (tmr_q == '0) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else begin
            tmr_d = tmr_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_prev_q    <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            par_q         <= 1'b0;
            tmr_q         <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_q         <= 8'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            clk_s1_q      <= ps2_clk;
            clk_s2_q      <= clk_s1_q;
            clk_prev_q    <= clk_s2_q;
            dat_s1_q      <= ps2_data;
            dat_s2_q      <= dat_s1_q;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            tmr_q         <= tmr_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_q         <= key_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign key         = {8'h00, key_q};
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_kbd_ps2_rx.sv
// Bench for kbd_ps2_rx: bit-bangs PS/2 frames and compares key/pulses against a
// table-driven model of the set-2 make/break rules.
module tb_kbd_ps2_rx;

    localparam int HALF = 20;
    // 2-flop synchronizer plus the edge-detect flop: a ps2_clk fall driven at a
    // negedge is acted on 3 clk edges later.
    localparam int EDGE_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key;
    logic        fv, fe;

    int nc = 0;
    int ne = 0;
    int cyc = 0;
    int n_valid = 0, n_err = 0, n_both = 0;
    int last_valid_cyc = 0, last_err_cyc = 0, last_fall_cyc = 0;

    int         map0 [256];
    int         map1 [256];
    bit         m_ext, m_brk;
    logic [7:0] m_key;

    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [44];

    kbd_ps2_rx #(.TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key), .frame_valid(fv), .frame_err(fe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fv === 1'b1) begin n_valid++; last_valid_cyc = cyc; end
        if (fe === 1'b1) begin n_err++; last_err_cyc = cyc; end
        if (fv === 1'b1 && fe === 1'b1) n_both++;
    end

    function automatic void model_init();
        for (int i = 0; i < 256; i++) begin map0[i] = -1; map1[i] = -1; end
        for (int i = 0; i < 26; i++) begin map0[letters[i]] = 65 + i; pool[i] = letters[i]; end
        for (int i = 0; i < 10; i++) begin map0[digits[i]] = 48 + i; pool[26+i] = digits[i]; end
        map0[8'h29] = 32;  map0[8'h5A] = 128; map0[8'h66] = 129; map0[8'h76] = 140;
        map1[8'h6B] = 130; map1[8'h75] = 131; map1[8'h74] = 132; map1[8'h72] = 133;
        pool[36] = 8'h29; pool[37] = 8'h5A; pool[38] = 8'h66; pool[39] = 8'h76;
        pool[40] = 8'h6B; pool[41] = 8'h75; pool[42] = 8'h74; pool[43] = 8'h72;
        m_ext = 0; m_brk = 0; m_key = 8'd0;
    endfunction

    function automatic void model_good(input logic [7:0] b);
        int v;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            v = m_ext ? map1[b] : map0[b];
            if (v >= 0) begin
                if (!m_brk) m_key = v[7:0];
                else if (int'(m_key) == v) m_key = 8'd0;
            end
            m_ext = 0; m_brk = 0;
        end
    endfunction

    function automatic void model_bad();
        m_ext = 0; m_brk = 0;
    endfunction

    task automatic ps2_edge(input logic d);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit stop, input int nedges);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nedges; i++) ps2_edge(f[i]);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        send_bits(b, bad_par, stop, 11);
        if (!bad_par && stop) model_good(b);
        else model_bad();
    endtask

    task automatic test_reset();
        model_init();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nc++; if (key !== 16'd0) begin ne++; $display("FAIL reset_key got %0d want 0", key); end
        nc++; if (fv !== 1'b0) begin ne++; $display("FAIL reset_valid got %b want 0", fv); end
        nc++; if (fe !== 1'b0) begin ne++; $display("FAIL reset_err got %b want 0", fe); end
    endtask

    task automatic test_make();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 0, 1);
        nc++; if (n_valid - v0 !== 1) begin ne++; $display("FAIL make_valid_pulses got %0d want 1", n_valid - v0); end
        nc++; if (n_err - e0 !== 0) begin ne++; $display("FAIL make_err_pulses got %0d want 0", n_err - e0); end
        nc++; if (last_valid_cyc - last_fall_cyc !== EDGE_LAT) begin
            ne++; $display("FAIL make_valid_latency got %0d want %0d", last_valid_cyc - last_fall_cyc, EDGE_LAT); end
        nc++; if (key !== 16'd65) begin ne++; $display("FAIL make_key got %0d want 65", key); end
    endtask

    task automatic test_break();
        int v0;
        v0 = n_valid;
        send_frame(8'hF0, 0, 1);
        nc++; if (n_valid - v0 !== 1) begin ne++; $display("FAIL break_prefix_valid got %0d want 1", n_valid - v0); end
        nc++; if (key !== 16'd65) begin ne++; $display("FAIL break_prefix_key got %0d want 65", key); end
        send_frame(8'h1C, 0, 1);
        nc++; if (key !== 16'd0) begin ne++; $display("FAIL break_key got %0d want 0", key); end
    endtask

    task automatic test_ext();
        int v0;
        send_frame(8'hE0, 0, 1);
        send_frame(8'h75, 0, 1);
        nc++; if (key !== 16'd131) begin ne++; $display("FAIL ext_make_key got %0d want 131", key); end
        send_frame(8'hE0, 0, 1);
        send_frame(8'hF0, 0, 1);
        send_frame(8'h75, 0, 1);
        nc++; if (key !== 16'd0) begin ne++; $display("FAIL ext_break_key got %0d want 0", key); end
        send_frame(8'h1C, 0, 1);
        v0 = n_valid;
        send_frame(8'h75, 0, 1);
        nc++; if (key !== 16'd65) begin ne++; $display("FAIL unmapped_key got %0d want 65", key); end
        nc++; if (n_valid - v0 !== 1) begin ne++; $display("FAIL unmapped_valid got %0d want 1", n_valid - v0); end
    endtask

    task automatic test_bad_frame();
        int v0, e0;
        send_frame(8'h32, 0, 1);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1, 1);
        nc++; if (n_err - e0 !== 1) begin ne++; $display("FAIL parity_err_pulses got %0d want 1", n_err - e0); end
        nc++; if (n_valid - v0 !== 0) begin ne++; $display("FAIL parity_valid_pulses got %0d want 0", n_valid - v0); end
        nc++; if (last_err_cyc - last_fall_cyc !== EDGE_LAT) begin
            ne++; $display("FAIL parity_err_latency got %0d want %0d", last_err_cyc - last_fall_cyc, EDGE_LAT); end
        nc++; if (key !== 16'd66) begin ne++; $display("FAIL parity_key got %0d want 66", key); end
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 0, 0);
        nc++; if (n_err - e0 !== 1) begin ne++; $display("FAIL stop_err_pulses got %0d want 1", n_err - e0); end
        nc++; if (n_valid - v0 !== 0) begin ne++; $display("FAIL stop_valid_pulses got %0d want 0", n_valid - v0); end
        nc++; if (key !== 16'd66) begin ne++; $display("FAIL stop_key got %0d want 66", key); end
        // A bad frame must drop a pending break prefix: 0x32 then acts as a make.
        send_frame(8'hF0, 0, 1);
        send_frame(8'h21, 1, 1);
        send_frame(8'h32, 0, 1);
        nc++; if (key !== 16'd66) begin ne++; $display("FAIL prefix_clear_key got %0d want 66", key); end
    endtask

    task automatic test_timeout();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_bits(8'h1C, 0, 1, 5);
        model_bad();
        for (int i = 0; i < 300 && cyc < last_fall_cyc + 110; i++) @(negedge clk);
        nc++; if (n_err - e0 !== 1) begin ne++; $display("FAIL timeout_err_pulses got %0d want 1", n_err - e0); end
        nc++; if (last_err_cyc - last_fall_cyc !== 100 + EDGE_LAT) begin
            ne++; $display("FAIL timeout_latency got %0d want %0d", last_err_cyc - last_fall_cyc, 100 + EDGE_LAT); end
        nc++; if (n_valid - v0 !== 0) begin ne++; $display("FAIL timeout_valid_pulses got %0d want 0", n_valid - v0); end
        send_frame(8'h29, 0, 1);
        nc++; if (key !== 16'd32) begin ne++; $display("FAIL timeout_next_key got %0d want 32", key); end
    endtask

    task automatic test_rollover();
        send_frame(8'h1C, 0, 1);
        nc++; if (key !== 16'd65) begin ne++; $display("FAIL roll_first_key got %0d want 65", key); end
        send_frame(8'h32, 0, 1);
        nc++; if (key !== 16'd66) begin ne++; $display("FAIL roll_second_key got %0d want 66", key); end
        send_frame(8'hF0, 0, 1);
        send_frame(8'h1C, 0, 1);
        nc++; if (key !== 16'd66) begin ne++; $display("FAIL roll_break_key got %0d want 66", key); end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        send_frame(8'hE0, 0, 1);
        e0 = n_err;
        send_bits(8'h45, 0, 1, 6);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_key = 8'd0; m_ext = 0; m_brk = 0;
        repeat (150) @(negedge clk);
        nc++; if (key !== 16'd0) begin ne++; $display("FAIL midreset_key got %0d want 0", key); end
        nc++; if (n_err - e0 !== 0) begin ne++; $display("FAIL midreset_err_pulses got %0d want 0", n_err - e0); end
        send_frame(8'h75, 0, 1);
        nc++; if (key !== 16'd0) begin ne++; $display("FAIL midreset_ext_cleared got %0d want 0", key); end
        send_frame(8'h16, 0, 1);
        nc++; if (key !== 16'd49) begin ne++; $display("FAIL midreset_next_key got %0d want 49", key); end
    endtask

    task automatic test_random();
        int         kind, v0, e0;
        logic [7:0] b;
        bit         bad_par, stop;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            bad_par = 0; stop = 1;
            if (kind <= 1) b = 8'hE0;
            else if (kind <= 3) b = 8'hF0;
            else if (kind <= 7) b = pool[$urandom_range(0, 43)];
            else b = 8'($urandom_range(0, 255));
            if (kind == 9) begin
                if ($urandom_range(0, 1) == 1) bad_par = 1;
                else stop = 0;
            end
            v0 = n_valid; e0 = n_err;
            send_frame(b, bad_par, stop);
            nc++; if (key !== {8'h00, m_key}) begin
                ne++; $display("FAIL rand_key it=%0d byte=%h got %0d want %0d", it, b, key, m_key); end
            nc++; if (n_valid - v0 !== int'(!bad_par && stop) || n_err - e0 !== int'(bad_par || !stop)) begin
                ne++; $display("FAIL rand_pulses it=%0d byte=%h valid=%0d err=%0d want good=%0d",
                               it, b, n_valid - v0, n_err - e0, !bad_par && stop); end
        end
        nc++; if (n_both !== 0) begin ne++; $display("FAIL valid_err_overlap got %0d want 0", n_both); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext();
        test_bad_frame();
        test_timeout();
        test_rollover();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nc, ne);
        $finish;
    end

endmodule

// File: doc/kbd_ps2_rx.md
KBD_PS2_RX -- requirements
Module: kbd_ps2_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000: clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned.
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ps2_clk, input, 1: PS/2 device clock, asynchronous to clk.
REQ-005 SHALL have port ps2_data, input, 1: PS/2 device data, asynchronous to clk.
REQ-006 SHALL have port key, output, 16: Hack keyboard word feeding the KEYBOARD register at address 24576; 0 = no key.
REQ-007 SHALL have port frame_valid, output, 1: one-cycle pulse per correctly received byte.
REQ-008 SHALL have port frame_err, output, 1: one-cycle pulse per parity, stop-bit or timeout failure.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; all logic uses synchronized copies only.
REQ-010 SHALL detect a ps2_clk falling edge as synchronized previous=1, current=0; sample ps2_data only on that cycle.
REQ-011 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: edge with data=0 -> DATA, bit count 0; edge with data=1 -> stay IDLE, no pulse.
REQ-013 DATA: shift 8 bits LSB first; after 8th bit -> PARITY.
REQ-014 PARITY: capture bit -> STOP.
REQ-015 STOP: on edge, frame good iff stop=1 and (8 data bits + parity) has odd count of ones; -> IDLE either way.
REQ-016 Good frame: frame_valid=1 for exactly the cycle after the stop-bit edge; key update (if any) on that same edge.
REQ-017 Bad frame: frame_err=1 for one cycle; byte discarded; key unchanged; prefix flags cleared.
REQ-018 Timeout: in DATA/PARITY/STOP, TIMEOUT consecutive cycles with no falling edge -> IDLE, frame_err one cycle; counter resets on every edge and in IDLE.
REQ-019 Byte 0xE0 SHALL set ext flag; 0xF0 SHALL set brk flag; neither changes key.
REQ-020 Any other good byte SHALL be translated with current flags, then clear both flags.
REQ-021 Translation (set 2, ext=0): letters A-Z (1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A) -> 65-90; digits 0-9 (45,16,1E,26,25,2E,36,3D,3E,46) -> 48-57; 29->32; 5A->128; 66->129; 76->140.
REQ-022 Translation (ext=1): 6B->130, 75->131, 74->132, 72->133; all other codes unmapped.
REQ-023 Unmapped codes ext=0 likewise unmapped; unmapped byte SHALL not change key but still pulses frame_valid.
REQ-024 Make (brk=0) of mapped code SHALL load key with translated value, replacing any held key.
REQ-025 Break (brk=1) of mapped code SHALL clear key to 0 only if key equals translated value; else key unchanged.
REQ-026 key[15:8] SHALL always be 0.
REQ-027 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-028 reset=1 at a rising edge SHALL force state IDLE, bit count 0, shift/parity registers 0, timeout counter 0, ext=brk=0, key=0, frame_valid=0, frame_err=0, synchronizer flops 1.
REQ-029 reset mid-frame SHALL abandon the frame with no frame_err; next frame received normally after reset deasserts.

Verification
REQ-030 Frame 0x1C (start 0, bits, parity 0, stop 1) -> frame_valid one cycle, key=65.
REQ-031 Frames 0x1C then F0,1C -> key 65 then 0; F0 causes frame_valid but key stays 65 until 0x1C break.
REQ-032 Frames E0,75 -> key=131; then E0,F0,75 -> key=0; 0x75 alone (ext=0) -> key unchanged.
REQ-033 Frame 0x1C with parity 1 -> frame_err one cycle, frame_valid 0, key unchanged; stop bit 0 -> same.
REQ-034 TIMEOUT=100, stop ps2_clk after 4 data bits -> frame_err exactly at cycle 100 after last edge, state IDLE; following good 0x29 -> key=32.
REQ-035 Make 0x1C, make 0x32, break 0x1C -> key 65, 66, 66; reset asserted mid-frame -> key=0, no frame_err.
